// File: rtl/sound_pkg.sv
// Clip table shared by the sound arbiter: clip indices, one-hot selects and ROM start/end addresses.
package sound_pkg;

    localparam int NUM_CLIPS   = 4;
    localparam int CLIP_WIN    = 0;
    localparam int CLIP_MOO    = 1;
    localparam int CLIP_DETECT = 2;
    localparam int CLIP_CHEER  = 3;

    localparam logic [NUM_CLIPS-1:0] SEL_WIN    = NUM_CLIPS'(1 << CLIP_WIN);
    localparam logic [NUM_CLIPS-1:0] SEL_MOO    = NUM_CLIPS'(1 << CLIP_MOO);
    localparam logic [NUM_CLIPS-1:0] SEL_DETECT = NUM_CLIPS'(1 << CLIP_DETECT);
    localparam logic [NUM_CLIPS-1:0] SEL_CHEER  = NUM_CLIPS'(1 << CLIP_CHEER);

    localparam logic [31:0] WIN_START    = 32'd0;
    localparam logic [31:0] WIN_END      = 32'd16395;
    localparam logic [31:0] MOO_START    = 32'd16396;
    localparam logic [31:0] MOO_END      = 32'd66982;
    localparam logic [31:0] DETECT_START = 32'd66983;
    localparam logic [31:0] DETECT_END   = 32'd83254;
    localparam logic [31:0] CHEER_START  = 32'd83255;
    localparam logic [31:0] CHEER_END    = 32'd137138;

    function automatic logic [31:0] clip_start(input logic [NUM_CLIPS-1:0] sel);
        case (sel)
            SEL_WIN:    return WIN_START;
            SEL_MOO:    return MOO_START;
            SEL_DETECT: return DETECT_START;
            SEL_CHEER:  return CHEER_START;
            default:    return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] clip_end(input logic [NUM_CLIPS-1:0] sel);
        case (sel)
            SEL_WIN:    return WIN_END;
            SEL_MOO:    return MOO_END;
            SEL_DETECT: return DETECT_END;
            SEL_CHEER:  return CHEER_END;
            default:    return 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/sound_prio_enc.sv
// Fixed-priority encoder over the pending clip requests; lowest index wins.
module sound_prio_enc
    import sound_pkg::*;
(
    input  logic [NUM_CLIPS-1:0] pending,
    output logic [NUM_CLIPS-1:0] winner,
    output logic                 valid
);

    // x & -x isolates the lowest set bit
    always_comb begin
        winner = pending & (~pending + NUM_CLIPS'(1));
        valid  = |pending;
    end

endmodule

// File: rtl/sound_arbiter.sv
// Sound clip arbiter: latches play requests, streams the winning clip from the sample ROM to the codec.
// Build option: PREEMPT_EN lets a higher-priority request restart playback immediately.
//   state | meaning
//   IDLE  | nothing playing, waiting for a pending request
//   LOAD  | grant and start address set, first sample being fetched
//   PLAY  | stepping rom_addr once per CLK_DIV cycles until the clip end
module sound_arbiter
    import sound_pkg::*;
#(
    parameter int CLK_DIV  = 1200,
    parameter int ADDR_W   = 18,
    parameter int SAMPLE_W = 6
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic [3:0]           req,
    input  logic                 abort,
    output logic [ADDR_W-1:0]    rom_addr,
    input  logic [SAMPLE_W-1:0]  rom_q,
    input  logic                 audio_out_allowed,
    output logic                 write_audio_out,
    output logic [31:0]          left_channel_audio_out,
    output logic [31:0]          right_channel_audio_out,
    output logic [3:0]           grant,
    output logic                 busy,
    output logic                 done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_PLAY = 2'd2;

    localparam int TICK_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_DIV - 1);

    logic [1:0]          state_q;
    logic [3:0]          pending_q;
    logic [3:0]          winner;
    logic                win_valid;
    logic [TICK_W-1:0]   tick_q;
    logic                addr_chg_q;
    logic [SAMPLE_W-1:0] sample_q;
    logic                sample_pending_q;
    logic                tick_wrap;
    logic                at_end;
    logic                do_load;

    sound_prio_enc u_prio (
        .pending (pending_q),
        .winner  (winner),
        .valid   (win_valid)
    );

    always_comb begin
        tick_wrap = (state_q == ST_PLAY) && (tick_q == TICK_LAST);
        at_end    = (rom_addr == ADDR_W'(clip_end(grant)));
`ifdef PREEMPT_EN
        // one-hot compare: a smaller value is a lower index, i.e. higher priority
        do_load   = win_valid && ((state_q == ST_IDLE) ||
                                  ((state_q == ST_PLAY) && (winner < grant)));
`else
        do_load   = win_valid && (state_q == ST_IDLE);
`endif
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            pending_q        <= '0;
            grant            <= '0;
            rom_addr         <= '0;
            tick_q           <= '0;
            addr_chg_q       <= 1'b0;
            sample_q         <= '0;
            sample_pending_q <= 1'b0;
            done             <= 1'b0;
        end else if (abort) begin
            state_q          <= ST_IDLE;
            pending_q        <= '0;
            grant            <= '0;
            tick_q           <= '0;
            addr_chg_q       <= 1'b0;
            sample_pending_q <= 1'b0;
            done             <= 1'b0;
        end else begin
            done       <= 1'b0;
            addr_chg_q <= 1'b0;
            pending_q  <= (pending_q & ~(do_load ? winner : 4'b0000)) | req;

            if (addr_chg_q) begin
                sample_q         <= rom_q;
                sample_pending_q <= 1'b1;
            end else if (write_audio_out) begin
                sample_pending_q <= 1'b0;
            end

            if (do_load) begin
                state_q    <= ST_LOAD;
                grant      <= winner;
                rom_addr   <= ADDR_W'(clip_start(winner));
                tick_q     <= '0;
                addr_chg_q <= 1'b1;
            end else begin
                case (state_q)
                    ST_LOAD: state_q <= ST_PLAY;
                    ST_PLAY: begin
                        if (tick_wrap) begin
                            tick_q <= '0;
                            if (at_end) begin
                                state_q          <= ST_IDLE;
                                grant            <= '0;
                                done             <= 1'b1;
                                sample_pending_q <= 1'b0;
                            end else begin
                                rom_addr   <= rom_addr + ADDR_W'(1);
                                addr_chg_q <= 1'b1;
                            end
                        end else begin
                            tick_q <= tick_q + TICK_W'(1);
                        end
                    end
                    ST_IDLE: state_q <= ST_IDLE;
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign busy                    = (state_q != ST_IDLE);
    assign write_audio_out         = sample_pending_q && audio_out_allowed && busy;
    assign left_channel_audio_out  = {sample_q, {(32-SAMPLE_W){1'b0}}};
    assign right_channel_audio_out = 32'd0;

endmodule

// File: doc/sound_arbiter.md
SOUND_ARBITER -- requirements
Module: sound_arbiter

Interface
REQ-001 Parameter CLK_DIV, default 1200, CLOCK_50 cycles per sample tick.
REQ-002 Parameter ADDR_W, default 18, sample-ROM address width.
REQ-003 Parameter SAMPLE_W, default 6, sample-ROM data width.
REQ-004 CLOCK_50  in  1  sole clock; all logic on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 req  in  4  per-clip play request pulses: [0] win, [1] moo, [2] detect, [3] cheer.
REQ-007 abort  in  1  stop the current clip and clear all pending requests.
REQ-008 rom_addr  out  ADDR_W  sample-ROM address.
REQ-009 rom_q  in  SAMPLE_W  sample-ROM data; valid one cycle after rom_addr changes.
REQ-010 audio_out_allowed  in  1  codec FIFO can accept a sample.
REQ-011 write_audio_out  out  1  one-cycle write strobe to the codec.
REQ-012 left_channel_audio_out  out  32  {sample, zeros}, left-justified.
REQ-013 right_channel_audio_out  out  32  constant zero.
REQ-014 grant  out  4  one-hot clip currently playing; zero when idle.
REQ-015 busy  out  1  high in any state other than IDLE.
REQ-016 done  out  1  one-cycle pulse when a clip plays to its end address.

Function
REQ-017 Any req bit high for one cycle sets its pending bit; the bit stays set until that clip is granted or abort fires.
REQ-018 Arbitration is fixed priority, lowest index highest.
REQ-019 The FSM has three states: IDLE, LOAD, PLAY.
REQ-020 IDLE to LOAD when any pending bit is set; LOAD clears the winner's pending bit, sets grant, sets rom_addr to the clip start and clears the tick counter.
REQ-021 LOAD to PLAY after one cycle.
REQ-022 In PLAY the tick counter counts 0..CLK_DIV-1 and wraps; each wrap increments rom_addr by 1.
REQ-023 One cycle after every rom_addr change (including LOAD), rom_q is captured into the sample register and sample_pending is set.
REQ-024 write_audio_out = sample_pending AND audio_out_allowed; a write clears sample_pending.
REQ-025 A new capture while sample_pending is still set overwrites the sample; no stall.
REQ-026 At a wrap where rom_addr equals the clip end, the FSM pulses done, clears grant and goes to IDLE; the end sample is written before exit.
REQ-027 abort in any state forces IDLE and clears grant, pending, sample_pending and the tick counter; done is not pulsed.
REQ-028 abort and req in the same cycle: abort wins, req is dropped.
REQ-029 A req for the clip currently playing while in PLAY is latched and replays that clip after done.
REQ-030 In IDLE, rom_addr holds its last value and write_audio_out is 0.

Reset
REQ-031 On reset: FSM=IDLE; rom_addr, tick counter, pending, grant, sample register, sample_pending all 0; busy, done and write_audio_out all 0.
REQ-032 Reset asserted mid-clip takes effect immediately; no done pulse; pending requests are lost.

Configuration
REQ-033 With PREEMPT_EN defined, a pending request of higher priority than grant in PLAY forces LOAD next cycle; the preempted clip gets no done pulse and is not resumed.
REQ-034 Without PREEMPT_EN, requests in PLAY only latch and are arbitrated on return to IDLE.

Structure
REQ-035 Shared package sound_pkg: clip index constants and start/end constants WIN 0/16395, MOO 16396/66982, DETECT 66983/83254, CHEER 83255/137138.
REQ-036 Sub-module sound_prio_enc: 4-bit fixed-priority encoder giving a one-hot winner and a valid flag.

Verification
REQ-037 CLK_DIV=4, audio_out_allowed=1, req=0001 -> rom_addr steps 0..16395 every 4 cycles; 16396 writes; done once; grant returns to 0000.
REQ-038 req=1010 in the same cycle -> moo (start 16396) plays first, then cheer (start 83255); two done pulses.
REQ-039 Moo playing at addr 20000, req=0001 pulsed -> with PREEMPT_EN, grant=0001 and rom_addr=0 within 2 cycles, no done; without it, win starts after moo's done.
REQ-040 abort at addr 70000 in detect with req[3] pending -> IDLE next cycle; grant=0, busy=0, no done; cheer does not start.
REQ-041 audio_out_allowed held low for 3 ticks, then high -> exactly one write, carrying the latest sample.
REQ-042 reset asserted mid-PLAY -> all outputs 0 in the same cycle, asynchronously; normal restart on the next req.
